test_checker: RTL

Self-checking scoreboard that drives the `pass`/`fail` inputs of the test status monitor. It buffers a stream of expected values, compares it in order against the DUT output stream, and counts mismatches. It declares a sticky, mutually exclusive pass or fail verdict when any of these occurs:
- a programmed number of checks completes;
- an error budget is exhausted;
- the output stream stalls past a watchdog limit.

---
 rtl/test_checker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/test_checker.sv
// test_checker: in-order scoreboard comparing an expected stream against
// an observed stream, with sticky pass/fail, error budget and watchdog.
module test_checker #(
  parameter string PREFIX     = "TEST_CHECKER",
  parameter int    DATA_W     = 16,
  parameter int    NUM_CHECKS = 64,
  parameter int    FIFO_DEPTH = 8,
  parameter int    MAX_ERRORS = 1,
  parameter int    TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  output logic              obs_ready,
  output logic              pass,
  output logic              fail,
  output logic              timed_out,
  output logic [15:0]       err_count,
  output logic [31:0]       check_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LP_MAXE = 32'(MAX_ERRORS);
  localparam logic [31:0] LP_NCHK = 32'(NUM_CHECKS);
  localparam logic [31:0] LP_TO   = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [15:0]       r_err_cnt;
  logic [31:0]       r_chk_cnt;
  logic [31:0]       r_idle;
  logic              r_timed_out;

  logic              w_run;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic              w_mismatch;
  logic [15:0]       w_err_nxt;
  logic [31:0]       w_chk_nxt;
  logic              w_timed_nxt;

  assign w_run   = (r_state == S_RUN);
  // Same index with differing wrap bits means the buffer is full
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign exp_ready = w_run && !w_full;
  assign obs_ready = w_run && !w_empty;

  assign w_push     = exp_valid && exp_ready;
  assign w_pop      = obs_valid && obs_ready;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_mismatch = (w_head != obs_data);

  assign w_err_nxt = (w_mismatch && (r_err_cnt != 16'hFFFF)) ?
                     r_err_cnt + 16'd1 : r_err_cnt;
  assign w_chk_nxt = r_chk_cnt + 32'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_timed_nxt = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_pop) begin
          if ({16'd0, w_err_nxt} >= LP_MAXE) begin
            w_state_nxt = S_FAIL;
          end else if (w_chk_nxt == LP_NCHK) begin
            w_state_nxt = (w_err_nxt == 16'd0) ? S_PASS : S_FAIL;
          end
        end else if (r_idle == LP_TO) begin
          w_state_nxt = S_FAIL;
          w_timed_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_err_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_idle      <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_err_cnt <= w_err_nxt;
        r_chk_cnt <= w_chk_nxt;
        r_idle    <= '0;
      end else if (w_run) begin
        r_idle <= r_idle + 32'd1;
      end
      if (w_timed_nxt) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= exp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_pop && w_mismatch) begin
      $display("%s: check %0d differs exp=0x%h obs=0x%h",
               PREFIX, r_chk_cnt, w_head, obs_data);
    end
    if (!reset && w_timed_nxt) begin
      $display("%s: watchdog expired after %0d idle cycles",
               PREFIX, r_idle);
    end
  end
`endif

  assign pass        = (r_state == S_PASS);
  assign fail        = (r_state == S_FAIL);
  assign timed_out   = r_timed_out;
  assign err_count   = r_err_cnt;
  assign check_count = r_chk_cnt;

endmodule
